// File: rtl/triple_mult_engine.sv
// triple_mult_engine: signed 8x8x8 multiply via sequential shift-add, operands loaded from and product stored to a byte-wide data memory
module triple_mult_engine #(
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data
);
  typedef enum logic [3:0] {IDLE, LD_A, LD_B, LD_C, MUL1, MUL2, SIGN, ST_HI, ST_MID, ST_LO, DONE} state_t;
  state_t state_q, state_d;
  logic start_q;
  logic [7:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d, mag_c_q, mag_c_d, mplier_q, mplier_d;
  logic sign_q, sign_d;
  logic [23:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic fall;
  logic [7:0] rd_mag;
  logic [23:0] acc_add;
  assign fall = ~start & start_q;
  assign rd_mag = mem_rd_data[7] ? ~mem_rd_data + 8'd1 : mem_rd_data;
  assign acc_add = acc_q + (mplier_q[0] ? mcand_q : 24'd0);
  always_ff @(posedge clk) begin
    start_q <= start;
    if (reset) begin
      state_q  <= IDLE;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      mag_c_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      mag_c_q  <= mag_c_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    mag_c_d     = mag_c_q;
    mplier_d    = mplier_q;
    sign_d      = sign_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    done        = 1'b0;
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (state_q)
      IDLE, DONE: begin
        done = state_q == DONE;
        if (fall) state_d = LD_A;
      end
      LD_A: begin
        mem_addr = 8'(IN_BASE);
        mag_a_d  = rd_mag;
        sign_d   = mem_rd_data[7];
        state_d  = LD_B;
      end
      LD_B: begin
        mem_addr = 8'(IN_BASE + 1);
        mag_b_d  = rd_mag;
        sign_d   = sign_q ^ mem_rd_data[7];
        state_d  = LD_C;
      end
      LD_C: begin
        mem_addr = 8'(IN_BASE + 2);
        mag_c_d  = rd_mag;
        sign_d   = sign_q ^ mem_rd_data[7];
        mcand_d  = {16'd0, mag_a_q};
        mplier_d = mag_b_q;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = MUL1;
      end
      MUL1, MUL2: begin
        acc_d    = acc_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = state_q == MUL1 ? MUL2 : SIGN;
          // The finished P1 becomes the multiplicand of the second pass
          if (state_q == MUL1) begin
            mcand_d  = acc_add;
            mplier_d = mag_c_q;
            acc_d    = '0;
          end
        end
      end
      SIGN: begin
        acc_d   = sign_q ? ~acc_q + 24'd1 : acc_q;
        state_d = ST_HI;
      end
      ST_HI: begin
        mem_wr_en   = 1'b1;
        mem_addr    = 8'(OUT_BASE);
        mem_wr_data = acc_q[23:16];
        state_d     = ST_MID;
      end
      ST_MID: begin
        mem_wr_en   = 1'b1;
        mem_addr    = 8'(OUT_BASE + 1);
        mem_wr_data = acc_q[15:8];
        state_d     = ST_LO;
      end
      ST_LO: begin
        mem_wr_en   = 1'b1;
        mem_addr    = 8'(OUT_BASE + 2);
        mem_wr_data = acc_q[7:0];
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_triple_mult_engine.sv
// tb_triple_mult_engine: directed runs with a result scoreboard checked on each rising done
module tb_triple_mult_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b1;
  logic done, mem_wr_en;
  logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
  logic [7:0] mem [0:255];
  logic [23:0] exp_q[$];
  int tests = 0;
  int errs = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int writes = 0;
  logic done_p = 1'b0;

  triple_mult_engine #(.IN_BASE(0), .OUT_BASE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;
  assign mem_rd_data = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      writes <= writes + 1;
      chk("wr_addr_not_input", {31'd0, mem_addr > 8'd2}, 32'd1);
    end
  end

  initial forever begin
    @(negedge clk);
    if (done && !done_p) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        chk("result", {8'd0, mem[4], mem[5], mem[6]}, {8'd0, exp_q.pop_front()});
        chk("latency", cyc - edge_cyc, 23);
      end
    end
    done_p = done;
  end

  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    mem[0] <= a;
    mem[1] <= b;
    mem[2] <= c;
    mem[4] <= 8'h55;
    mem[5] <= 8'h55;
    mem[6] <= 8'h55;
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    load(a, b, c);
    start = 1'b0;
    edge_cyc = cyc + 1;
    @(negedge clk);
    chk("done_low_after_edge", {31'd0, done}, 32'd0);
    start = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [23:0] e);
    exp_q.push_back(e);
    launch(a, b, c);
    wait_done();
    chk("inputs_unchanged", {8'd0, mem[0], mem[1], mem[2]}, {8'd0, a, b, c});
  endtask

  int w0;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run(8'd2, 8'd3, 8'd4, 24'h000018);
    run(-8'sd2, -8'sd20, 8'd4, 24'h0000A0);
    run(8'd32, 8'd32, -8'sd32, 24'hFF8000);
    run(8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF);
    run(8'h80, 8'h80, 8'h80, 24'hE00000);
    run(8'd0, 8'd1, 8'd1, 24'h000000);
    chk("idle_addr", {24'd0, mem_addr}, 32'd0);
    launch(8'd1, 8'd2, 8'd3);
    repeat (6) @(negedge clk);
    w0 = writes;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("abort_addr", {24'd0, mem_addr}, 32'd0);
    mem[0] <= 8'd5;
    mem[1] <= -8'sd6;
    mem[2] <= 8'd7;
    reset = 1'b0;
    start = 1'b0;
    exp_q.push_back(24'hFFFF2E);
    edge_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b1;
    chk("abort_no_writes", writes - w0, 0);
    chk("abort_mem_untouched", {8'd0, mem[4], mem[5], mem[6]}, 32'h00555555);
    wait_done();
    chk("post_abort_writes", writes - w0, 3);
    exp_q.push_back(24'hFFFFC4);
    launch(8'd3, -8'sd4, 8'd5);
    repeat (5) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_done();
    chk("done_held", {31'd0, done}, 32'd1);
    run(8'd7, 8'd7, -8'sd7, 24'hFFFEA9);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
